// File: rtl/clk_gate_pkg.sv
// ---------------------------------------------------------------------------
// clk_gate_pkg: shared state encoding and counter sizing for clk_gate_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } dom_state_t;

  // One counter serves both the wake delay and the idle timeout.
  function automatic int cnt_width(input int idle_cyc, input int wake_cyc);
    int m;
    int w;
    m = (idle_cyc > wake_cyc) ? idle_cyc : wake_cyc;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gate_dom_fsm.sv
// ---------------------------------------------------------------------------
// clk_gate_dom_fsm: OFF/WAKE/ON sequencer and counter for one gated domain
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_gate_dom_fsm
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic wreq,
  input  logic grant,
  output logic gate_en,
  output logic rdy,
  output logic wake_req,
  output logic is_off
);

  localparam logic [CNT_W-1:0] C_WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] C_IDLE_LD = CNT_W'(IDLE_CYC - 1);

  dom_state_t       r_state;
  dom_state_t       w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_gate_en;
  logic             r_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_gate_en <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_gate_en <= (w_state_nx != ST_OFF);
      r_rdy     <= (w_state_nx == ST_ON);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (grant) begin
          w_state_nx = ST_WAKE;
          w_cnt_nx   = C_WAKE_LD;
        end
      end
      ST_WAKE: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_ON;
          w_cnt_nx   = C_IDLE_LD;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_ON: begin
        // Activity on the final idle cycle still wins over gating off.
        if (act) begin
          w_cnt_nx = C_IDLE_LD;
        end else if (r_cnt == '0) begin
          w_state_nx = ST_OFF;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_OFF;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign gate_en  = r_gate_en;
  assign rdy      = r_rdy;
  assign is_off   = (r_state == ST_OFF);
  assign wake_req = is_off & wreq;

endmodule

`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl: per-domain clock-gate enables with round-robin wake arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             force_on,
  input  logic [N_DOM-1:0] req,
  input  logic [N_DOM-1:0] busy,
  output logic [N_DOM-1:0] gate_en,
  output logic [N_DOM-1:0] rdy,
  output logic             wake_pend
);

  localparam int CNT_W = cnt_width(IDLE_CYC, WAKE_CYC);
  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic [N_DOM-1:0] w_wreq;
  logic [N_DOM-1:0] w_act;
  logic [N_DOM-1:0] w_wake_req;
  logic [N_DOM-1:0] w_is_off;
  logic [N_DOM-1:0] w_grant;
  logic             w_gnt_any;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_ptr_nx;
  logic             w_pend;
  logic [PTR_W-1:0] r_ptr;
  logic             r_wake_pend;

  assign w_wreq = req | {N_DOM{force_on}};
  assign w_act  = req | busy | {N_DOM{force_on}};

  genvar gi;
  generate
    for (gi = 0; gi < N_DOM; gi++) begin : g_dom
      clk_gate_dom_fsm #(
        .IDLE_CYC (IDLE_CYC),
        .WAKE_CYC (WAKE_CYC),
        .CNT_W    (CNT_W)
      ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .act      (w_act[gi]),
        .wreq     (w_wreq[gi]),
        .grant    (w_grant[gi]),
        .gate_en  (gate_en[gi]),
        .rdy      (rdy[gi]),
        .wake_req (w_wake_req[gi]),
        .is_off   (w_is_off[gi])
      );
    end
  endgenerate

  // Scan from r_ptr upward with wrap; first requester found wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gidx    = '0;
    w_idx     = '0;
    for (int i = 0; i < N_DOM; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % N_DOM);
      if (!rst && !w_gnt_any && w_wake_req[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gnt_any      = 1'b1;
        w_gidx         = w_idx;
      end
    end
  end

  assign w_ptr_nx = (w_gidx == PTR_W'(N_DOM - 1)) ? '0 : w_gidx + 1'b1;
  assign w_pend   = |(w_is_off & w_wreq & ~w_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_wake_pend <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_ptr <= w_ptr_nx;
      end
      r_wake_pend <= w_pend;
    end
  end

  assign wake_pend = r_wake_pend;

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl: directed vector table plus multi-cycle sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       force_on;
  logic [3:0] req;
  logic [3:0] busy;
  logic [3:0] gate_en;
  logic [3:0] rdy;
  logic       wake_pend;

  int checks   = 0;
  int failures = 0;

  clk_gate_ctrl #(
    .N_DOM    (4),
    .IDLE_CYC (16),
    .WAKE_CYC (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .force_on  (force_on),
    .req       (req),
    .busy      (busy),
    .gate_en   (gate_en),
    .rdy       (rdy),
    .wake_pend (wake_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fon;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] gate;
    logic [3:0] rdy;
    logic       wp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; force_on = 1'b0; req = '0; busy = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] eg;
    logic [3:0] er;

    // Basic wake of domain 0, reset, then four-way contention from ptr=0.
    vecs[0]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0011, 4'b0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0111, 4'b0001, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0011, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0111, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0};

    do_reset();
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("tbl%0d_gate_en", j), 32'(gate_en), 32'(vecs[j].gate));
      chk($sformatf("tbl%0d_rdy", j), 32'(rdy), 32'(vecs[j].rdy));
      chk($sformatf("tbl%0d_wake_pend", j), 32'(wake_pend), 32'(vecs[j].wp));
      rst = vecs[j].rst; force_on = vecs[j].fon; req = vecs[j].req; busy = vecs[j].busy;
      tick();
    end

    // Idle-off: last active cycle 4, fall at 21.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("idle_c%0d_gate", c), 32'(gate_en[0]), 32'(c >= 1 && c < 21));
      chk($sformatf("idle_c%0d_rdy", c), 32'(rdy[0]), 32'(c >= 3 && c < 21));
      req = (c <= 4) ? 4'b0001 : 4'b0000;
      tick();
    end

    // busy in the cnt==0 cycle (20) keeps the domain on until 37.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("busy_c%0d_gate", c), 32'(gate_en[0]), 32'(c >= 1 && c < 37));
      chk($sformatf("busy_c%0d_rdy", c), 32'(rdy[0]), 32'(c >= 3 && c < 37));
      req  = (c <= 4) ? 4'b0001 : 4'b0000;
      busy = (c == 20) ? 4'b0001 : 4'b0000;
      tick();
    end

    // Fairness: after domain 2 is granted, 3 beats 1.
    do_reset();
    req = 4'b0100; tick();
    req = 4'b1010; tick();
    chk("fair_c2_gate", 32'(gate_en), 32'(4'b1100));
    chk("fair_c2_wp", 32'(wake_pend), 32'(1'b1));
    tick();
    req = 4'b0000;
    chk("fair_c3_gate", 32'(gate_en), 32'(4'b1110));
    chk("fair_c3_wp", 32'(wake_pend), 32'(1'b0));

    // force_on for 40 cycles: one wake per cycle, all off at 56.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        eg[i] = (c >= i + 1) && (c < 56);
        er[i] = (c >= i + 3) && (c < 56);
      end
      chk($sformatf("fon_c%0d_gate", c), 32'(gate_en), 32'(eg));
      chk($sformatf("fon_c%0d_rdy", c), 32'(rdy), 32'(er));
      force_on = (c < 40);
      tick();
    end
    force_on = 1'b0;

    // Reset during domain 0's wake, with domain 2 left pending.
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0110; tick();
    chk("rstw_c2_wp", 32'(wake_pend), 32'(1'b1));
    chk("rstw_c2_gate", 32'(gate_en), 32'(4'b0011));
    rst = 1'b1; tick();
    chk("rstw_c3_gate", 32'(gate_en), 32'(4'b0000));
    chk("rstw_c3_rdy", 32'(rdy), 32'(4'b0000));
    chk("rstw_c3_wp", 32'(wake_pend), 32'(1'b0));
    rst = 1'b0; req = 4'b0000; tick();
    chk("rstw_c4_rdy", 32'(rdy), 32'(4'b0000));
    req = 4'b1111; tick();
    chk("rstw_c5_gate_ptr0", 32'(gate_en), 32'(4'b0001));
    chk("rstw_c5_rdy", 32'(rdy), 32'(4'b0000));
    req = 4'b0000; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Wake/sleep controller for a bank of clock-gated domains. Each domain's clock passes through a gating cell: an enable register clocked by `clk`, ANDed with `clk`. This block drives that cell's enable input, turns the clock off after a programmable idle period, and reports when each domain's clock is usable. Wake-ups are arbitrated round-robin, so at most one domain's clock is switched on per cycle, which limits current steps on the supply.

## Interface
Parameters:
- `N_DOM`, 4: number of gated domains (1..16).
- `IDLE_CYC`, 16: consecutive inactive cycles before a domain is gated off (≥1).
- `WAKE_CYC`, 2: cycles from `gate_en` rising to `rdy` rising. Covers the gating cell's enable register plus settle time (≥1).

Ports:
- `clk`  in  1: single system clock; the gating cells use it too.
- `rst`  in  1: synchronous, active-high reset.
- `force_on`  in  1: global override; every domain is treated as active.
- `req`  in  N_DOM: per-domain wake/activity request.
- `busy`  in  N_DOM: domain reports in-flight work; keeps an ON domain from idling. Ignored while the domain is OFF.
- `gate_en`  out  N_DOM: enable to each gating cell.
- `rdy`  out  N_DOM: the domain's gated clock is running and stable.
- `wake_pend`  out  1: at least one OFF domain is requesting but has not yet been granted.

## Operation
- Each domain has its own FSM with states OFF, WAKE and ON, plus its own counter.
- Activity for domain i is `act[i] = req[i] | busy[i] | force_on`.
- OFF:
  - `gate_en=0`, `rdy=0`.
  - The domain requests a wake grant when `req[i] | force_on`.
  - On grant: go to WAKE, load `cnt = WAKE_CYC-1`.
- WAKE:
  - `gate_en=1`, `rdy=0`.
  - If `cnt==0`: go to ON and load `cnt = IDLE_CYC-1`. Otherwise decrement `cnt`.
  - Inputs are ignored; a wake always completes.
- ON:
  - `gate_en=1`, `rdy=1`.
  - If `act[i]`: reload `cnt = IDLE_CYC-1`.
  - Else if `cnt==0`: go to OFF.
  - Else: decrement `cnt`.
  - Activity in the cycle where `cnt==0` wins: the domain stays ON and the counter reloads.
- Wake arbiter:
  - Combinational round-robin over domains that are in OFF and requesting; one grant per cycle.
  - A pointer `ptr` gives the highest-priority index. After a grant to index g, `ptr = (g+1) mod N_DOM`. With no grant, `ptr` holds.
- `wake_pend` is registered. It is high whenever at least one OFF domain requested in the previous cycle and did not receive that cycle's grant.
- Counter width is `$clog2(max(IDLE_CYC,WAKE_CYC))`, minimum 1 bit. Counters never wrap below 0.
- Reset (synchronous, takes priority in any state): all FSMs go to OFF, `cnt=0`, `ptr=0`, `gate_en=0`, `rdy=0`, `wake_pend=0`.
  - Reset asserted during WAKE or ON drops `gate_en` and `rdy` on the next edge.
  - No grants are issued while `rst=1`.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Wake latency: `req[i]` high in cycle 0 and granted in cycle 0. Then:
  - `gate_en[i]=1` from cycle 1.
  - `rdy[i]=1` from cycle `1+WAKE_CYC`.
  - Each cycle spent waiting for a grant adds one cycle to both.
- Idle latency: the last active cycle is k. Then `gate_en[i]` and `rdy[i]` both fall together at the start of cycle `k+IDLE_CYC+1`.
- `rdy` never rises in a cycle where `gate_en` was low in the prior cycle. `rdy` never stays high once `gate_en` is low.
- `force_on` rising while N domains are OFF wakes them one per cycle, in round-robin order starting at `ptr`.

## Structure
- Package `clk_gate_pkg`:
  - State encoding constants `ST_OFF=2'd0`, `ST_WAKE=2'd1`, `ST_ON=2'd2`.
  - Counter-width function.
- Sub-module `clk_gate_dom_fsm`: one domain's FSM and counter.
  - Inputs: `clk`, `rst`, `act`, `wreq`, `grant`.
  - Outputs: `gate_en`, `rdy`, `wake_req`, `is_off`.
  - Instantiated `N_DOM` times through a generate loop.
- The top level contains the round-robin arbiter, `ptr`, and `wake_pend`.

## Test plan
All scenarios use `N_DOM=4`, `IDLE_CYC=16`, `WAKE_CYC=2`.
- Basic wake: `req[0]` pulsed in cycle 0 → `gate_en[0]=1` from cycle 1, `rdy[0]=1` from cycle 3.
- Idle-off: after the wake above, no activity with last active cycle k → `gate_en[0]` and `rdy[0]` fall at cycle k+17. Re-run with `busy[0]` pulsed in the cycle where `cnt==0` → the domain stays ON and the fall moves 16 cycles later.
- Contention: `req=4'b1111` in cycle 0 with `ptr=0` → `gate_en` bits rise in cycles 1, 2, 3, 4 for domains 0–3. `rdy` bits rise in cycles 3–6. `wake_pend=1` in cycles 1–3, then 0 from cycle 4.
- Fairness: after domain 2 is granted, `req[1]` and `req[3]` are raised together while both are OFF → domain 3 is granted first.
- `force_on`: all domains OFF, `force_on=1` for 40 cycles → all domains wake in round-robin order, none gate off while `force_on` is high, then all gate off 16 cycles after `force_on` falls.
- Reset mid-wake: `rst` asserted in cycle 2 of domain 0's wake → `gate_en[0]=0`, `rdy[0]=0`, `ptr=0` and `wake_pend=0` at the next edge; `rdy[0]` never pulses.
